mips_regfile_sb: RTL and testbench
==================================

Name: mips_regfile_sb

Overview:
- Parametrised successor to the CPU's flat register array and write-back logic.
- Register file with NUM_RD combinational read ports, one write-back port, and a per-register pending-write scoreboard.
- Sits between decode (read, issue) and write-back. Produces the decode stall for RAW hazards on results that are still in flight.
- Replaces the fixed 32x32 array with single-cycle write and no hazard tracking.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers (power of 2, >=2). AW = log2(NUM_REGS).
- NUM_RD, 2, number of read ports.
- PEND_W, 2, scoreboard counter width. Maximum in-flight writes per register = 2^PEND_W-1.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- rd_en  in  NUM_RD  read port i is used by the issuing instruction.
- rd_addr  in  NUM_RD*AW  read addresses, port i at [i*AW +: AW].
- rd_data  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W].
- issue_valid  in  1  decode is presenting an instruction this cycle.
- issue_wr  in  1  the issuing instruction writes a register.
- issue_dst  in  AW  destination of the issuing instruction.
- wb_valid  in  1  write-back this cycle.
- wb_dst  in  AW  write-back destination.
- wb_data  in  DATA_W  write-back value.
- flush  in  1  discard all in-flight writes (branch/exception).
- stall  out  1  issuing instruction must be held.
- sb_err  out  1  sticky: write-back to a register with zero pending count, or counter saturation attempt.

Behaviour:
- Reset (Reset_n=0, async): all registers = 0, all pend counters = 0, sb_err = 0. stall and rd_data are combinational; with the inputs idle they evaluate to stall=0 and rd_data=0.
- Register 0 is hardwired: it always reads 0, writes to it are ignored, and it is never marked pending.
- Write: on posedge, if wb_valid and wb_dst!=0, reg[wb_dst] <= wb_data. Write latency is 1 cycle.
- Read: combinational, rd_data[i] = reg[rd_addr[i]]. Bypass behaviour is defined under Optional Feature.
- busy[i] = rd_en[i] & rd_addr[i]!=0 & pend[rd_addr[i]]!=0 & !resolved[i].
  - resolved[i] = bypass enabled & wb_valid & wb_dst==rd_addr[i] & pend[rd_addr[i]]==1.
- sat = issue_wr & issue_dst!=0 & pend[issue_dst]==all-ones.
- stall = issue_valid & (OR busy[i] | sat). stall is 0 when flush=1.
- Issue accept: issue_valid & !stall & !flush.
  - If also issue_wr & issue_dst!=0, pend[issue_dst] increments.
- Write-back: if wb_valid & wb_dst!=0 & pend[wb_dst]!=0, pend[wb_dst] decrements.
  - If pend[wb_dst]==0 instead, the counter is unchanged, the data is still written, and sb_err <= 1.
- Accepted issue and write-back to the same register in the same cycle: the counter is unchanged (net 0).
- flush: all counters <= 0 on the next edge, overriding any increment or decrement. A wb_valid in the same cycle still writes data.
  - Write-backs that arrive after a flush for already-cleared entries set sb_err. Upstream must squash them, so this counts as a real error.
- sat with issue_valid: stall asserted and sb_err <= 1.
- sb_err is cleared only by reset.
- Reset asserted mid-operation: immediate clear of all state. No pending write completes.

Optional Feature:
- Macro MIPS_RF_BYPASS_EN.
- Defined:
  - rd_data[i] = wb_data when wb_valid & wb_dst==rd_addr[i] & rd_addr[i]!=0; otherwise stored data.
  - resolved[i] is active, so a reader whose last outstanding write retires this cycle does not stall.
- Undefined:
  - no bypass mux; rd_data is always the stored value.
  - resolved[i] is forced to 0, so the reader stalls one extra cycle and reads the updated register after the edge.

Test Plan:
- Reset, then read ports at r0, r5 -> rd_data=0,0; stall=0; sb_err=0. Write wb r0=0xDEAD -> r0 still reads 0.
- Issue r3 write (pend=1), next cycle issue reading r3 -> stall=1. Hold until wb r3=0x1234.
  - Bypass on: stall=0 in the wb cycle and rd_data=0x1234.
  - Bypass off: stall=0 one cycle later, rd_data=0x1234.
- Three issues writing r7 with PEND_W=2 -> pend=3. Fourth issue to r7 -> stall=1, sb_err=1.
- Issue writing r4 and wb r4 in the same cycle with pend=1 -> pend stays 1. Reader of r4 still stalls until the next wb.
- pend r2=1, r9=2, then flush -> all pend 0, reader of r9 not stalled. Later wb r9 -> data written, sb_err=1.
- Assert Reset_n=0 asynchronously while pend r6=1 -> r6 reads 0, stall=0, sb_err=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_regfile_sb_if.sv
// Decode/write-back bus of the register file with scoreboard.
// master = pipeline side (decode + write-back), slave = register file.
interface mips_regfile_sb_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2
);
    localparam int unsigned AW = $clog2(NUM_REGS);

    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     issue_valid;
    logic                     issue_wr;
    logic [AW-1:0]            issue_dst;
    logic                     wb_valid;
    logic [AW-1:0]            wb_dst;
    logic [DATA_W-1:0]        wb_data;
    logic                     flush;
    logic                     stall;
    logic                     sb_err;

    modport master (
        output rd_en, rd_addr, issue_valid, issue_wr, issue_dst,
        output wb_valid, wb_dst, wb_data, flush,
        input  rd_data, stall, sb_err
    );

    modport slave (
        input  rd_en, rd_addr, issue_valid, issue_wr, issue_dst,
        input  wb_valid, wb_dst, wb_data, flush,
        output rd_data, stall, sb_err
    );
endinterface

// File: rtl/mips_regfile_sb.sv
// Register file with NUM_RD read ports, one write-back port and a per-register
// pending-write scoreboard driving the decode stall. MIPS_RF_BYPASS_EN enables write-back bypass.
module mips_regfile_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned PEND_W   = 2
) (
    input  logic               Clk,
    input  logic               Reset_n,
    mips_regfile_sb_if.slave   bus
);
    localparam int unsigned AW = $clog2(NUM_REGS);

    logic [DATA_W-1:0]        regs_q [NUM_REGS];
    logic [DATA_W-1:0]        regs_d [NUM_REGS];
    logic [PEND_W-1:0]        pend_q [NUM_REGS];
    logic [PEND_W-1:0]        pend_d [NUM_REGS];
    logic                     sb_err_q;
    logic                     sb_err_d;

    logic [AW-1:0]            rd_a     [NUM_RD];
    logic                     resolved [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] rd_data_c;
    logic                     busy_any;
    logic                     sat;
    logic                     stall_c;
    logic                     issue_inc;
    logic                     wb_hit;

    always_comb begin
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd_a[i] = bus.rd_addr[i*AW +: AW];
        end
    end

    // Register 0 is never written, so regs_q[0] stays zero and reads of r0 need no special case.
    always_comb begin
        busy_any  = 1'b0;
        rd_data_c = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
`ifdef MIPS_RF_BYPASS_EN
            resolved[i] = bus.wb_valid && (bus.wb_dst == rd_a[i]) &&
                          (pend_q[rd_a[i]] == PEND_W'(1));
            rd_data_c[i*DATA_W +: DATA_W] =
                (bus.wb_valid && (bus.wb_dst == rd_a[i]) && (rd_a[i] != '0)) ?
                bus.wb_data : regs_q[rd_a[i]];
`else
            resolved[i] = 1'b0;
            rd_data_c[i*DATA_W +: DATA_W] = regs_q[rd_a[i]];
`endif
            if (bus.rd_en[i] && (rd_a[i] != '0) && (pend_q[rd_a[i]] != '0) && !resolved[i]) begin
                busy_any = 1'b1;
            end
        end
    end

    always_comb begin
        sat     = bus.issue_wr && (bus.issue_dst != '0) && (pend_q[bus.issue_dst] == '1);
        stall_c = bus.issue_valid && !bus.flush && (busy_any || sat);
    end

    always_comb begin
        regs_d    = regs_q;
        pend_d    = pend_q;
        sb_err_d  = sb_err_q;
        issue_inc = bus.issue_valid && !stall_c && !bus.flush &&
                    bus.issue_wr && (bus.issue_dst != '0);
        wb_hit    = bus.wb_valid && (bus.wb_dst != '0);

        if (wb_hit) begin
            regs_d[bus.wb_dst] = bus.wb_data;
            if (pend_q[bus.wb_dst] == '0) begin
                sb_err_d = 1'b1;
            end
        end
        if (bus.issue_valid && sat) begin
            sb_err_d = 1'b1;
        end

        // Issue and write-back hitting the same register cancel; flush overrides both.
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (bus.flush) begin
                pend_d[r] = '0;
            end else if (issue_inc && (bus.issue_dst == AW'(r)) &&
                         !(wb_hit && (bus.wb_dst == AW'(r)))) begin
                pend_d[r] = pend_q[r] + 1'b1;
            end else if (wb_hit && (bus.wb_dst == AW'(r)) &&
                         !(issue_inc && (bus.issue_dst == AW'(r))) &&
                         (pend_q[r] != '0)) begin
                pend_d[r] = pend_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            pend_q   <= pend_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign bus.rd_data = rd_data_c;
    assign bus.stall   = stall_c;
    assign bus.sb_err  = sb_err_q;
endmodule

// File: tb/tb_mips_regfile_sb.sv
// Self-checking bench for mips_regfile_sb: directed scenarios then random traffic
// checked against an array-based reference model of the scoreboard rules.
module tb_mips_regfile_sb;
    localparam int DW   = 32;
    localparam int NR   = 32;
    localparam int NRD  = 2;
    localparam int PW   = 2;
    localparam int AW   = 5;
    localparam int PMAX = (1 << PW) - 1;
`ifdef MIPS_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset_n;
    always #5 Clk = ~Clk;

    mips_regfile_sb_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) bus ();

    mips_regfile_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .PEND_W(PW)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_reg  [NR];
    int            m_pend [NR];
    bit            m_err;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_reg[r]  = '0;
            m_pend[r] = 0;
        end
        m_err = 1'b0;
    endtask

    function automatic int port_addr(input int i);
        logic [NRD*AW-1:0] a;
        a = bus.rd_addr;
        return int'(a[i*AW +: AW]);
    endfunction

    function automatic bit exp_stall();
        bit busy = 1'b0;
        bit sat;
        for (int i = 0; i < NRD; i++) begin
            int a = port_addr(i);
            bit retiring = BYP && bus.wb_valid && int'(bus.wb_dst) == a && m_pend[a] == 1;
            if (bus.rd_en[i] && a != 0 && m_pend[a] > 0 && !retiring) busy = 1'b1;
        end
        sat = bus.issue_wr && bus.issue_dst != 0 && m_pend[bus.issue_dst] == PMAX;
        return bus.issue_valid && !bus.flush && (busy || sat);
    endfunction

    function automatic logic [DW-1:0] exp_rd(input int i);
        int a = port_addr(i);
        if (a == 0) return '0;
        if (BYP && bus.wb_valid && int'(bus.wb_dst) == a) return bus.wb_data;
        return m_reg[a];
    endfunction

    function automatic logic [DW-1:0] dut_rd(input int i);
        logic [NRD*DW-1:0] d;
        d = bus.rd_data;
        return d[i*DW +: DW];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_stall"}, DW'(bus.stall), DW'(exp_stall()));
        for (int i = 0; i < NRD; i++) chk($sformatf("%s_rd%0d", tag, i), dut_rd(i), exp_rd(i));
        chk({tag, "_sb_err"}, DW'(bus.sb_err), DW'(m_err));
    endtask

    // Next-state of the model from the inputs present before the edge.
    task automatic model_edge();
        bit st  = exp_stall();
        bit sat = bus.issue_wr && bus.issue_dst != 0 && m_pend[bus.issue_dst] == PMAX;
        bit inc = bus.issue_valid && !st && !bus.flush && bus.issue_wr && bus.issue_dst != 0;
        bit wb  = bus.wb_valid && bus.wb_dst != 0;
        if (bus.issue_valid && sat) m_err = 1'b1;
        if (wb) begin
            m_reg[bus.wb_dst] = bus.wb_data;
            if (m_pend[bus.wb_dst] == 0) m_err = 1'b1;
        end
        if (bus.flush) begin
            for (int r = 0; r < NR; r++) m_pend[r] = 0;
        end else if (!(inc && wb && bus.issue_dst == bus.wb_dst)) begin
            if (inc) m_pend[bus.issue_dst] += 1;
            if (wb && m_pend[bus.wb_dst] > 0) m_pend[bus.wb_dst] -= 1;
        end
    endtask

    task automatic idle();
        bus.rd_en = '0; bus.rd_addr = '0; bus.issue_valid = 0; bus.issue_wr = 0;
        bus.issue_dst = '0; bus.wb_valid = 0; bus.wb_dst = '0; bus.wb_data = '0; bus.flush = 0;
    endtask

    task automatic set_rd(input int i, input bit en, input int a);
        bus.rd_en[i] = en;
        bus.rd_addr[i*AW +: AW] = AW'(a);
    endtask

    task automatic set_issue(input bit v, input bit wr, input int dst);
        bus.issue_valid = v; bus.issue_wr = wr; bus.issue_dst = AW'(dst);
    endtask

    task automatic set_wb(input bit v, input int dst, input logic [DW-1:0] data);
        bus.wb_valid = v; bus.wb_dst = AW'(dst); bus.wb_data = data;
    endtask

    task automatic settle(input string tag);
        #1;
        check_all(tag);
    endtask

    task automatic advance();
        model_edge();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic step(input string tag);
        settle(tag);
        advance();
    endtask

    task automatic apply_reset();
        Reset_n = 1'b0;
        idle();
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    initial begin
        idle();
        model_reset();
        apply_reset();

        // Reset state, r0 hardwired
        set_rd(0, 1, 0); set_rd(1, 1, 5);
        settle("reset");
        chk("reset_rd1_r5", dut_rd(1), 32'h0);
        chk("reset_stall", DW'(bus.stall), 32'h0);
        advance();
        idle(); set_wb(1, 0, 32'hDEAD);
        step("wb_r0");
        idle(); set_rd(0, 1, 0);
        settle("read_r0");
        chk("r0_still_zero", dut_rd(0), 32'h0);
        advance();

        // RAW on r3
        idle(); set_issue(1, 1, 3);
        step("issue_r3");
        idle(); set_issue(1, 0, 0); set_rd(0, 1, 3);
        settle("raw_r3_a");
        chk("raw_r3_stall", DW'(bus.stall), 32'h1);
        advance();
        step("raw_r3_hold");
        set_wb(1, 3, 32'h1234);
        settle("raw_r3_wb");
        if (BYP) begin
            chk("byp_stall", DW'(bus.stall), 32'h0);
            chk("byp_data", dut_rd(0), 32'h1234);
        end else begin
            chk("nobyp_stall", DW'(bus.stall), 32'h1);
        end
        advance();
        set_wb(0, 0, '0);
        settle("raw_r3_after");
        chk("after_stall", DW'(bus.stall), 32'h0);
        chk("after_data", dut_rd(0), 32'h1234);
        advance();

        // Saturation on r7
        idle(); set_issue(1, 1, 7);
        for (int k = 0; k < PMAX; k++) step("fill_r7");
        settle("sat_r7");
        chk("sat_stall", DW'(bus.stall), 32'h1);
        advance();
        idle();
        settle("sat_err");
        chk("sat_sb_err", DW'(bus.sb_err), 32'h1);
        advance();

        // Same-cycle issue + wb on r4
        apply_reset();
        set_issue(1, 1, 4);
        step("issue_r4");
        set_issue(1, 1, 4); set_wb(1, 4, 32'h44);
        step("issue_wb_r4");
        idle(); set_issue(1, 0, 0); set_rd(1, 1, 4);
        settle("reader_r4");
        chk("r4_still_pending", DW'(bus.stall), 32'h1);
        advance();
        set_wb(1, 4, 32'h45);
        step("r4_retire");

        // Flush
        apply_reset();
        set_issue(1, 1, 2); step("issue_r2");
        set_issue(1, 1, 9); step("issue_r9a");
        step("issue_r9b");
        idle(); set_issue(1, 0, 0); set_rd(0, 1, 9);
        settle("pre_flush");
        chk("pre_flush_stall", DW'(bus.stall), 32'h1);
        advance();
        idle(); bus.flush = 1;
        step("flush");
        idle(); set_issue(1, 0, 0); set_rd(0, 1, 9);
        settle("post_flush");
        chk("post_flush_stall", DW'(bus.stall), 32'h0);
        advance();
        idle(); set_wb(1, 9, 32'h99);
        step("late_wb_r9");
        idle(); set_rd(0, 1, 9);
        settle("late_wb_chk");
        chk("late_wb_data", dut_rd(0), 32'h99);
        chk("late_wb_err", DW'(bus.sb_err), 32'h1);
        advance();

        // Asynchronous reset mid-operation
        idle(); set_issue(1, 1, 6); step("issue_r6");
        idle(); set_wb(1, 6, 32'h66); step("wb_r6");
        idle(); set_issue(1, 1, 6); step("issue_r6b");
        idle(); set_issue(1, 0, 0); set_rd(0, 1, 6);
        settle("pre_areset");
        #1;
        Reset_n = 1'b0;
        #1;
        chk("areset_rd", dut_rd(0), 32'h0);
        chk("areset_stall", DW'(bus.stall), 32'h0);
        chk("areset_err", DW'(bus.sb_err), 32'h0);
        model_reset();
        @(negedge Clk);
        Reset_n = 1'b1;

        // Random traffic against the model
        for (int n = 0; n < 500; n++) begin
            int dst;
            idle();
            for (int i = 0; i < NRD; i++) set_rd(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
            dst = int'($urandom_range(0, 7));
            set_issue(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), dst);
            if (m_pend[dst] == PMAX) bus.issue_wr = 1'b0;
            if ($urandom_range(0, 9) < 7) begin
                int w = int'($urandom_range(1, 7));
                if (m_pend[w] > 0) set_wb(1, w, $urandom());
                else if ($urandom_range(0, 9) == 0) set_wb(1, 0, $urandom());
            end
            bus.flush = ($urandom_range(0, 19) == 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL timeout: observed no finish, expected finish before 400000");
        $fatal(1, "timeout");
    end
endmodule
